// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer.
package demux_pkg;
    localparam int WIDTH_DEFAULT = 16;
    localparam int DEPTH_DEFAULT = 2;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/demux2_16b_stream_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head word is always presented on dout.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW:0]                 wr_ptr;
    logic [AW:0]                 rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // Full is judged on the pre-edge state: a pop in the same cycle does not make room.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign dout = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/demux2_16b_stream.sv
// 1-to-2 valid/ready demultiplexer: in_sel steers each word into the FIFO of port A or B.
module demux2_16b_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [15:0]      a_count,
    output logic [15:0]      b_count
);
    logic full_a, full_b;
    logic empty_a, empty_b;
    logic push_a, push_b;
    logic pop_a, pop_b;

    // Readiness depends only on the selected FIFO, never on the consumers' ready.
    assign in_ready = (in_sel == SEL_A) ? !full_a : !full_b;

    assign push_a = in_valid && in_ready && (in_sel == SEL_A);
    assign push_b = in_valid && in_ready && (in_sel == SEL_B);

    assign a_valid = !empty_a;
    assign b_valid = !empty_b;
    assign pop_a   = a_valid && a_ready;
    assign pop_b   = b_valid && b_ready;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .push  (push_a),
        .pop   (pop_a),
        .din   (in_data),
        .dout  (a_data),
        .full  (full_a),
        .empty (empty_a)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .push  (push_b),
        .pop   (pop_b),
        .din   (in_data),
        .dout  (b_data),
        .full  (full_b),
        .empty (empty_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (pop_a) a_count <= a_count + 16'd1;
            if (pop_b) b_count <= b_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_demux2_16b_stream.sv
// Randomized bench for demux2_16b_stream against a queue-based per-port reference model.
module tb_demux2_16b_stream;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a_data, b_data;
    logic        a_valid, b_valid;
    logic        a_ready = 1'b0;
    logic        b_ready = 1'b0;
    logic [15:0] a_count, b_count;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] ma_cnt, mb_cnt;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    demux2_16b_stream #(.WIDTH(16), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    // One clock edge; the model applies the handshake rules to its queues.
    task automatic tick();
        bit          pa, pb, pu;
        logic        s;
        logic [15:0] w;
        pa = a_ready && (qa.size() > 0);
        pb = b_ready && (qb.size() > 0);
        pu = in_valid && (in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
        s  = in_sel;
        w  = in_data;
        @(posedge clk);
        if (pa) begin qa.delete(0); ma_cnt = ma_cnt + 16'd1; end
        if (pb) begin qb.delete(0); mb_cnt = mb_cnt + 16'd1; end
        if (pu) begin
            if (s) qb.push_back(w);
            else   qa.push_back(w);
        end
        @(negedge clk);
    endtask

    task automatic clear_model();
        qa.delete();
        qb.delete();
        ma_cnt = '0;
        mb_cnt = '0;
    endtask

    task automatic apply_reset();
        in_valid = 0; a_ready = 0; b_ready = 0; in_sel = 0; in_data = '0;
        rst = 1;
        clear_model();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst = 1;
        #1;
        n_checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got a=%b b=%b want 0 0", a_valid, b_valid); end
        n_checks++; if (a_data !== 16'h0 || b_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got a=%h b=%h want 0000 0000", a_data, b_data); end
        n_checks++; if (a_count !== 16'h0 || b_count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got a=%0d b=%0d want 0 0", a_count, b_count); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        clear_model();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        in_valid = 1; in_sel = 0; in_data = 16'h0001;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL first_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 0;
        n_checks++; if (a_valid !== 1'b1 || a_data !== 16'h0001) begin n_fail++; $display("FAIL first_word: got v=%b d=%h want 1 0001", a_valid, a_data); end
        n_checks++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL first_b_idle: got %b want 0", b_valid); end
        // Buffer a B word too, then reset mid-operation without a clock edge.
        in_valid = 1; in_sel = 1; in_data = 16'hBEEF;
        tick();
        in_valid = 0;
        rst = 1;
        #1;
        n_checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0 || a_data !== 16'h0 || b_data !== 16'h0) begin
            n_fail++; $display("FAIL midop_reset: got av=%b bv=%b ad=%h bd=%h want 0 0 0000 0000", a_valid, b_valid, a_data, b_data);
        end
        clear_model();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_steering();
        logic [15:0] wa[3] = '{16'h0001, 16'h00FF, 16'hFFFF};
        logic [15:0] wb[3] = '{16'hAAAA, 16'h1234, 16'h0000};
        logic [15:0] got_a[$];
        logic [15:0] got_b[$];
        apply_reset();
        a_ready = 1; b_ready = 1;
        for (int i = 0; i < 10; i++) begin
            if (i < 6) begin
                in_valid = 1; in_sel = i[0]; in_data = i[0] ? wb[i/2] : wa[i/2];
            end else begin
                in_valid = 0;
            end
            if (a_valid && a_ready) got_a.push_back(a_data);
            if (b_valid && b_ready) got_b.push_back(b_data);
            tick();
        end
        n_checks++; if (got_a.size() != 3 || got_b.size() != 3) begin n_fail++; $display("FAIL steer_len: got a=%0d b=%0d want 3 3", got_a.size(), got_b.size()); end
        for (int i = 0; i < 3 && i < got_a.size() && i < got_b.size(); i++) begin
            n_checks++; if (got_a[i] !== wa[i] || got_b[i] !== wb[i]) begin
                n_fail++; $display("FAIL steer_word%0d: got a=%h b=%h want %h %h", i, got_a[i], got_b[i], wa[i], wb[i]);
            end
        end
        n_checks++; if (a_count !== 16'd3 || b_count !== 16'd3) begin n_fail++; $display("FAIL steer_count: got a=%0d b=%0d want 3 3", a_count, b_count); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        in_valid = 1; in_sel = 0; in_data = 16'h0F0F;
        tick();
        in_data = 16'hF0F0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_second_ready: got %b want 1", in_ready); end
        tick();
        in_data = 16'h5555;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_a: got in_ready=%b want 0", in_ready); end
        tick();
        in_sel = 1; in_data = 16'h1111;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_b_open: got in_ready=%b want 1", in_ready); end
        tick();
        in_valid = 0;
        n_checks++; if (b_valid !== 1'b1 || b_data !== 16'h1111) begin n_fail++; $display("FAIL bp_b_word: got v=%b d=%h want 1 1111", b_valid, b_data); end
        a_ready = 1;
        n_checks++; if (a_data !== 16'h0F0F) begin n_fail++; $display("FAIL bp_a_first: got %h want 0f0f", a_data); end
        tick();
        n_checks++; if (a_valid !== 1'b1 || a_data !== 16'hF0F0) begin n_fail++; $display("FAIL bp_a_second: got v=%b d=%h want 1 f0f0", a_valid, a_data); end
        tick();
        n_checks++; if (a_valid !== 1'b0 || a_count !== ma_cnt) begin n_fail++; $display("FAIL bp_a_drained: got v=%b cnt=%0d want 0 %0d", a_valid, a_count, ma_cnt); end
        b_ready = 1;
        tick();
    endtask

    task automatic test_full_pop();
        logic [15:0] got[$];
        logic [15:0] exp_w[3] = '{16'h0A01, 16'h0A02, 16'h0A03};
        apply_reset();
        in_valid = 1; in_sel = 0; in_data = 16'h0A01; tick();
        in_data = 16'h0A02; tick();
        a_ready = 1; in_data = 16'h0A03;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fullpop_blocked: got in_ready=%b want 0", in_ready); end
        if (a_valid) got.push_back(a_data);
        tick();
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_next: got in_ready=%b want 1", in_ready); end
        if (a_valid) got.push_back(a_data);
        tick();
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            if (a_valid) got.push_back(a_data);
            tick();
        end
        n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL fullpop_len: got %0d words want 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_w[i]) begin n_fail++; $display("FAIL fullpop_word%0d: got %h want %h", i, got[i], exp_w[i]); end
        end
        n_checks++; if (a_count !== 16'd3) begin n_fail++; $display("FAIL fullpop_count: got %0d want 3", a_count); end
    endtask

    task automatic test_alternating();
        int sent = 0;
        apply_reset();
        in_valid = 1; in_sel = 0; in_data = 16'($urandom);
        for (int c = 0; c < 400 && (sent < 16 || qa.size() > 0 || qb.size() > 0); c++) begin
            if (sent >= 16) begin
                in_valid = 0; a_ready = 1; b_ready = 1;
            end else begin
                a_ready = 1'($urandom); b_ready = 1'($urandom);
            end
            #1;
            n_checks++; if (a_valid !== (qa.size() > 0) || (qa.size() > 0 && a_data !== qa[0])) begin
                n_fail++; $display("FAIL alt_a: got v=%b d=%h want v=%b d=%h", a_valid, a_data, qa.size() > 0, (qa.size() > 0) ? qa[0] : 16'h0);
            end
            n_checks++; if (b_valid !== (qb.size() > 0) || (qb.size() > 0 && b_data !== qb[0])) begin
                n_fail++; $display("FAIL alt_b: got v=%b d=%h want v=%b d=%h", b_valid, b_data, qb.size() > 0, (qb.size() > 0) ? qb[0] : 16'h0);
            end
            if (in_valid) begin
                bit exp_rdy;
                exp_rdy = in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
                n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL alt_in_ready: got %b want %b", in_ready, exp_rdy); end
                tick();
                if (exp_rdy) begin
                    sent++;
                    in_sel  = sent[0];
                    in_data = 16'($urandom);
                end
            end else begin
                tick();
            end
        end
        in_valid = 0;
        n_checks++; if (sent != 16 || qa.size() != 0 || qb.size() != 0) begin n_fail++; $display("FAIL alt_timeout: sent=%0d left=%0d want 16 0", sent, qa.size() + qb.size()); end
        n_checks++; if (32'(a_count) + 32'(b_count) != 16 || a_count !== ma_cnt) begin
            n_fail++; $display("FAIL alt_counts: got a=%0d b=%0d want sum 16 a=%0d", a_count, b_count, ma_cnt);
        end
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        a_ready = 1; in_valid = 1; in_sel = 0;
        for (int i = 0; i < 65536; i++) begin
            in_data = 16'(i);
            tick();
        end
        in_valid = 0;
        n_checks++; if (a_count !== 16'hFFFF || a_data !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_pre: got cnt=%h d=%h want ffff ffff", a_count, a_data); end
        tick();
        n_checks++; if (a_count !== 16'h0000 || a_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_post: got cnt=%h v=%b want 0000 0", a_count, a_valid); end
        n_checks++; if (b_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_b_idle: got %h want 0000", b_count); end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_steering();
        test_backpressure();
        test_full_pop();
        test_alternating();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
